// File: rtl/sumador_pkg.sv
// Shared definitions for the byte-serial adder: FSM encodings and NBYTES limits.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NBYTES_MIN = 1;
  localparam int unsigned NBYTES_MAX = 8;
  // Byte index counter wide enough for NBYTES_MAX-1.
  localparam int unsigned CNT_W      = $clog2(NBYTES_MAX);

endpackage

// File: rtl/sumador_byte.sv
// One 8-bit full-adder stage, reused for every byte of the serial add.
module sumador_byte
  import sumador_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W:0] sum_c;

  // Widen before adding so the carry lands in the top bit.
  always_comb begin
    sum_c = (BYTE_W+1)'(a) + (BYTE_W+1)'(b) + (BYTE_W+1)'(ci);
  end

  assign s  = sum_c[BYTE_W-1:0];
  assign co = sum_c[BYTE_W];

endmodule

// File: rtl/sumador_serial.sv
// Byte-serial adder: {co,s} = a + b + ci, one byte per cycle, LSB byte first.
// Optional feature macro: SUMADOR_SERIAL_OVF_EN adds a registered signed-overflow
// output ovf (carry into bit W-1 XOR co).
module sumador_serial
  import sumador_pkg::*;
#(
  parameter int          PwrC   = 0,
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  ci,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   s,
  output logic                  co
`ifdef SUMADOR_SERIAL_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int unsigned W = BYTE_W * NBYTES;

  // Reject illegal configurations at elaboration; PwrC is only a tag.
  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX || PwrC < 0) begin : g_bad_cfg
    $error("sumador_serial: NBYTES must be in 1..8 and PwrC non-negative");
  end

  state_e state_q, state_d;

  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      s_q, s_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [BYTE_W-1:0] byte_a, byte_b, byte_s;
  logic              byte_co;
  logic              last_byte_c;

`ifdef SUMADOR_SERIAL_OVF_EN
  logic              ovf_q, ovf_d;
  logic              msb_cin_c;
`endif

  assign last_byte_c = (cnt_q == CNT_W'(NBYTES - 1));

  // Select the current byte of the captured operands.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        byte_a = a_q[BYTE_W*i +: BYTE_W];
        byte_b = b_q[BYTE_W*i +: BYTE_W];
      end
    end
  end

  sumador_byte u_byte (
    .a  (byte_a),
    .b  (byte_b),
    .ci (carry_q),
    .s  (byte_s),
    .co (byte_co)
  );

`ifdef SUMADOR_SERIAL_OVF_EN
  // Carry into the top bit of the MSB byte, recovered from its sum bit.
  assign msb_cin_c = byte_a[BYTE_W-1] ^ byte_b[BYTE_W-1] ^ byte_s[BYTE_W-1];
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)    state_d = RUN;
      RUN:     if (last_byte_c) state_d = DONE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // FSM output decode: handshake signals come straight from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: capture on accept, one byte per RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
`ifdef SUMADOR_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            s_d[BYTE_W*i +: BYTE_W] = byte_s;
          end
        end
        carry_d = byte_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_byte_c) begin
          co_d  = byte_co;
`ifdef SUMADOR_SERIAL_OVF_EN
          ovf_d = msb_cin_c ^ byte_co;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SUMADOR_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
`ifdef SUMADOR_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign s  = s_q;
  assign co = co_q;
`ifdef SUMADOR_SERIAL_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule
